// File: rtl/shift_defs.sv
// Shared state encodings and shift-type constants for the right shifter and ALU decode.
package shift_defs;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ARITH   = 1'b1;
endpackage

// File: rtl/one_bit_shift_right.sv
// Single-position right shift with an explicit fill bit; purely combinational.
module one_bit_shift_right #(
  parameter int n = 32
) (
  input  logic [n-1:0] i_num,
  input  logic         i_fill,
  output logic [n-1:0] o_res
);
  assign o_res = {i_fill, i_num[n-1:1]};
endmodule

// File: rtl/seq_shift_right_unit.sv
// Multi-cycle SRL/SRA: one bit per clock under a start/done handshake.
// done arrives shamt+1 cycles after accept; busy stalls the pipeline, flush kills the op.
module seq_shift_right_unit
  import shift_defs::*;
#(
  parameter int n  = 32,
  parameter int SW = $clog2(n)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [n-1:0]  i_num,
  input  logic [SW-1:0] i_shamt,
  input  logic          i_arith,
  input  logic          i_flush,
  output logic          o_busy,
  output logic          o_done,
  output logic [n-1:0]  o_res
);
  state_t        r_state;
  state_t        w_next;
  logic          w_accept;
  logic [n-1:0]  r_res;
  logic [SW-1:0] r_cnt;
  logic          r_fill;
  logic [n-1:0]  w_shifted;

  one_bit_shift_right #(.n(n)) u_step (
    .i_num  (r_res),
    .i_fill (r_fill),
    .o_res  (w_shifted)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = (i_shamt == '0) ? ST_DONE : ST_SHIFT;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == SW'(1)) begin
          w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    // Flush beats a same-cycle start: the request is dropped, not queued.
    if (i_flush) begin
      w_next   = ST_IDLE;
      w_accept = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_res  <= '0;
      r_cnt  <= '0;
      r_fill <= 1'b0;
    end else if (w_accept) begin
      r_res  <= i_num;
      r_cnt  <= i_shamt;
      r_fill <= (i_arith == SHIFT_ARITH) & i_num[n-1];
    end else if (r_state == ST_SHIFT) begin
      r_res <= w_shifted;
      r_cnt <= r_cnt - SW'(1);
    end
  end

  assign o_busy = (r_state == ST_SHIFT);
  assign o_done = (r_state == ST_DONE);
  assign o_res  = r_res;
endmodule

// File: tb/tb_seq_shift_right_unit.sv
// Directed bench for seq_shift_right_unit with hand-computed expected results.
module tb_seq_shift_right_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] num;
  logic [4:0]  shamt;
  logic        arith;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] res;

  int n_checks = 0;
  int n_fail   = 0;

  seq_shift_right_unit #(.n(32)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_num   (num),
    .i_shamt (shamt),
    .i_arith (arith),
    .i_flush (flush),
    .o_busy  (busy),
    .o_done  (done),
    .o_res   (res)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start and returns in the done cycle (or after the budget), no checking.
  task automatic launch_and_wait(input logic [31:0] a, input logic [4:0] s, input logic ar,
                                 output int done_cyc, output int busy_cyc);
    num = a; shamt = s; arith = ar; start = 1'b1;
    tick();
    start = 1'b0;
    done_cyc = -1;
    busy_cyc = 0;
    for (int k = 1; k <= 64; k++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc = k;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; num = '0; shamt = '0; arith = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL reset_res got %h want 00000000", res); end
  endtask

  task automatic test_logical();
    int dc, bc;
    launch_and_wait(32'h8000_0000, 5'd4, shift_defs::SHIFT_LOGICAL, dc, bc);
    n_checks++; if (dc !== 5) begin n_fail++; $display("FAIL srl_done_cycle got %0d want 5", dc); end
    n_checks++; if (bc !== 4) begin n_fail++; $display("FAIL srl_busy_cycles got %0d want 4", bc); end
    n_checks++; if (res !== 32'h0800_0000) begin n_fail++; $display("FAIL srl_res got %h want 08000000", res); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL srl_done_pulse got %b want 0", done); end
  endtask

  task automatic test_arith();
    int dc, bc;
    launch_and_wait(32'h8000_0000, 5'd4, shift_defs::SHIFT_ARITH, dc, bc);
    n_checks++; if (dc !== 5) begin n_fail++; $display("FAIL sra_done_cycle got %0d want 5", dc); end
    n_checks++; if (res !== 32'hF800_0000) begin n_fail++; $display("FAIL sra_neg_res got %h want f8000000", res); end
    launch_and_wait(32'h7000_0000, 5'd4, shift_defs::SHIFT_ARITH, dc, bc);
    n_checks++; if (res !== 32'h0700_0000) begin n_fail++; $display("FAIL sra_pos_res got %h want 07000000", res); end
  endtask

  task automatic test_zero_shamt();
    int dc, bc;
    launch_and_wait(32'h1234_5678, 5'd0, shift_defs::SHIFT_ARITH, dc, bc);
    n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL zero_done_cycle got %0d want 1", dc); end
    n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL zero_busy_cycles got %0d want 0", bc); end
    n_checks++; if (res !== 32'h1234_5678) begin n_fail++; $display("FAIL zero_res got %h want 12345678", res); end
  endtask

  task automatic test_max_shamt();
    int dc, bc;
    launch_and_wait(32'h8000_0000, 5'd31, shift_defs::SHIFT_ARITH, dc, bc);
    n_checks++; if (dc !== 32) begin n_fail++; $display("FAIL max_done_cycle got %0d want 32", dc); end
    n_checks++; if (bc !== 31) begin n_fail++; $display("FAIL max_busy_cycles got %0d want 31", bc); end
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL max_sra_res got %h want ffffffff", res); end
    launch_and_wait(32'h8000_0000, 5'd31, shift_defs::SHIFT_LOGICAL, dc, bc);
    n_checks++; if (res !== 32'h0000_0001) begin n_fail++; $display("FAIL max_srl_res got %h want 00000001", res); end
  endtask

  task automatic test_ignore_and_flush();
    int dc, bc;
    int seen_done;
    tick();
    // cycle T: start accepted at the end of this cycle
    num = 32'hFFFF_0000; shamt = 5'd8; arith = 1'b0; start = 1'b1;
    tick();
    // T+1: a second start with short shamt must be ignored
    num = 32'h0000_00FF; shamt = 5'd1; arith = 1'b1; start = 1'b1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy_t1 got %b want 1", busy); end
    tick();
    start = 1'b0;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ign_done_t2 got %b want 0", done); end
    tick();
    // T+3: flush
    flush = 1'b1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy_t3 got %b want 1", busy); end
    tick();
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_done got %b want 0", done); end
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) seen_done++;
      tick();
    end
    n_checks++; if (seen_done !== 0) begin n_fail++; $display("FAIL flush_quiet got %0d active cycles want 0", seen_done); end
    launch_and_wait(32'hFFFF_0000, 5'd8, shift_defs::SHIFT_LOGICAL, dc, bc);
    n_checks++; if (dc !== 9) begin n_fail++; $display("FAIL post_flush_done_cycle got %0d want 9", dc); end
    n_checks++; if (res !== 32'h00FF_FF00) begin n_fail++; $display("FAIL post_flush_res got %h want 00ffff00", res); end
  endtask

  task automatic test_back_to_back();
    int dc, bc;
    launch_and_wait(32'h0000_0F00, 5'd2, shift_defs::SHIFT_LOGICAL, dc, bc);
    n_checks++; if (res !== 32'h0000_03C0) begin n_fail++; $display("FAIL b2b_first_res got %h want 000003c0", res); end
    // Still in the DONE cycle: a start here must be accepted immediately.
    launch_and_wait(32'h0000_00F0, 5'd4, shift_defs::SHIFT_ARITH, dc, bc);
    n_checks++; if (dc !== 5) begin n_fail++; $display("FAIL b2b_done_cycle got %0d want 5", dc); end
    n_checks++; if (bc !== 4) begin n_fail++; $display("FAIL b2b_busy_cycles got %0d want 4", bc); end
    n_checks++; if (res !== 32'h0000_000F) begin n_fail++; $display("FAIL b2b_res got %h want 0000000f", res); end
  endtask

  task automatic test_reset_mid();
    int active;
    tick();
    num = 32'h8000_0000; shamt = 5'd10; arith = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    // T+2: reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got %b want 0", done); end
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL rstmid_res got %h want 00000000", res); end
    active = 0;
    for (int k = 0; k < 15; k++) begin
      if (done || busy) active++;
      tick();
    end
    n_checks++; if (active !== 0) begin n_fail++; $display("FAIL rstmid_quiet got %0d active cycles want 0", active); end
  endtask

  initial begin
    test_reset();
    test_logical();
    test_arith();
    test_zero_shamt();
    test_max_shamt();
    test_ignore_and_flush();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
